// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : State encoding and oversample constants shared by UART TX and RX.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned c_oversample  = 16;
    localparam logic [3:0]  c_sample_last = 4'(c_oversample - 1);

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_core
// Brief  : UART transmitter, 16x oversampled, configurable data/parity/stop.
// Rev    : 1.0
// ============================================================================
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick_16x,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] c_last_bit  = 3'(DATA_BITS - 1);
    localparam logic       c_last_stop = 1'(STOP_BITS - 1);

    uart_state_e          r_state;
    logic [3:0]           r_sample_cnt;
    logic [2:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic                 r_tx_done;

    logic w_bit_end;

    assign w_bit_end = baud_tick_16x && (r_sample_cnt == c_sample_last);

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;
    assign tx_done  = r_tx_done;
    assign tx_busy  = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sample_cnt <= 4'd0;
            r_bit_cnt    <= 3'd0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_tx         <= 1'b1;
            r_tx_ready   <= 1'b1;
            r_tx_done    <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;

            // The counter wraps 15->0 on its own, so each bit period restarts cleanly.
            if (r_state != IDLE && baud_tick_16x) begin
                r_sample_cnt <= r_sample_cnt + 4'd1;
            end

            case (r_state)
                IDLE: begin
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    if (tx_valid && r_tx_ready) begin
                        r_shift      <= tx_data;
                        r_parity     <= (^tx_data) ^ PARITY_ODD;
                        r_tx_ready   <= 1'b0;
                        r_tx         <= 1'b0;
                        r_sample_cnt <= 4'd0;
                        r_state      <= START;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_state   <= DATA;
                        r_bit_cnt <= 3'd0;
                        r_tx      <= r_shift[0];
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == c_last_bit) begin
                            r_stop_cnt <= 1'b0;
                            if (PARITY_EN) begin
                                r_state <= PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end

                PARITY: begin
                    if (w_bit_end) begin
                        r_state    <= STOP;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b1;
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_cnt == c_last_stop) begin
                            r_state    <= IDLE;
                            r_tx_done  <= 1'b1;
                            r_tx_ready <= 1'b1;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_core
// Brief  : Randomized bench for uart_tx_core across five frame formats.
// Rev    : 1.0
// ============================================================================
module tb_uart_tx_core;

    localparam int N       = 5;
    localparam int c_guard = 5000;

    // Per-instance formats: 8N1, 8E1, 8O1, 6O2, 5N2
    localparam logic [N-1:0][3:0] DB_P = {4'd5, 4'd6, 4'd8, 4'd8, 4'd8};
    localparam logic [N-1:0][1:0] SB_P = {2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    localparam logic [N-1:0]      PE_P = 5'b01110;
    localparam logic [N-1:0]      PO_P = 5'b01100;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b1;
    logic                 baud_tick = 1'b0;
    logic [N-1:0]         tx_valid  = '0;
    logic [N-1:0][7:0]    tx_data   = '0;
    logic                 tx_s   [N];
    logic                 rdy_s  [N];
    logic                 busy_s [N];
    logic                 done_s [N];

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_bits [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = int'(DB_P[g]);
        uart_tx_core #(
            .DATA_BITS (W),
            .STOP_BITS (int'(SB_P[g])),
            .PARITY_EN (PE_P[g]),
            .PARITY_ODD(PO_P[g])
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .baud_tick_16x(baud_tick),
            .tx_data      (tx_data[g][W-1:0]),
            .tx_valid     (tx_valid[g]),
            .tx_ready     (rdy_s[g]),
            .tx           (tx_s[g]),
            .tx_busy      (busy_s[g]),
            .tx_done      (done_s[g])
        );
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 baud_tick = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Expected line levels, one entry per bit period, from the frame format rules.
    function automatic void build_frame(input int idx, input logic [7:0] d);
        int ones;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < int'(DB_P[idx]); i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (PE_P[idx]) exp_bits.push_back(((ones % 2) == 1) ^ PO_P[idx]);
        for (int i = 0; i < int'(SB_P[idx]); i++) exp_bits.push_back(1'b1);
    endfunction

    task automatic check_idle_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check({tag, "_tx"},    32'(tx_s[i]),   32'd1);
            check({tag, "_ready"}, 32'(rdy_s[i]),  32'd1);
            check({tag, "_busy"},  32'(busy_s[i]), 32'd0);
            check({tag, "_done"},  32'(done_s[i]), 32'd0);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            check_idle_all("idle");
        end
    endtask

    // Called at a negedge; leaves at the negedge where tx_done is visible
    // (or right after a mid-frame reset when abort_at is reached).
    task automatic send_frame(input int idx, input logic [7:0] data, input bit hold,
                              input bit noise, input int abort_at);
        int k, total, guard;
        build_frame(idx, data);
        total = exp_bits.size() * 16;
        tx_data[idx]  = data;
        tx_valid[idx] = 1'b1;
        @(negedge clk);
        check("accept_ready", 32'(rdy_s[idx]),  32'd0);
        check("accept_busy",  32'(busy_s[idx]), 32'd1);
        check("accept_tx",    32'(tx_s[idx]),   32'd0);
        check("accept_done",  32'(done_s[idx]), 32'd0);
        if (!hold) tx_valid[idx] = 1'b0;
        k = 0;
        guard = 0;
        while (k < total && guard < c_guard) begin
            if (noise) begin
                if (k < total - 16) begin
                    tx_valid[idx] = 1'($urandom_range(0, 1));
                    tx_data[idx]  = 8'($urandom);
                end else begin
                    tx_valid[idx] = 1'b0;
                end
            end
            check("tx_bit",     32'(tx_s[idx]),   32'(exp_bits[k / 16]));
            check("frame_busy", 32'(busy_s[idx]), 32'd1);
            check("frame_rdy",  32'(rdy_s[idx]),  32'd0);
            check("early_done", 32'(done_s[idx]), 32'd0);
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_tx",    32'(tx_s[idx]),   32'd1);
                check("rst_ready", 32'(rdy_s[idx]),  32'd1);
                check("rst_busy",  32'(busy_s[idx]), 32'd0);
                check("rst_done",  32'(done_s[idx]), 32'd0);
                @(negedge clk);
                check_idle_all("in_reset");
                rst_n = 1'b1;
                return;
            end
            if (baud_tick) k++;
            @(negedge clk);
            guard++;
        end
        check("frame_in_time", 32'(guard < c_guard), 32'd1);
        check("end_done",  32'(done_s[idx]), 32'd1);
        check("end_ready", 32'(rdy_s[idx]),  32'd1);
        check("end_busy",  32'(busy_s[idx]), 32'd0);
        check("end_tx",    32'(tx_s[idx]),   32'd1);
    endtask

    initial begin
        int  idx;
        bit  hold;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_all("reset_state");
        rst_n = 1'b1;

        idle_cycles(20);
        send_frame(0, 8'hA5, 1'b0, 1'b0, -1);
        idle_cycles(3);

        // Back-to-back with tx_valid held across three frames
        send_frame(0, 8'h00, 1'b1, 1'b0, -1);
        send_frame(0, 8'hFF, 1'b1, 1'b0, -1);
        send_frame(0, 8'h5A, 1'b0, 1'b0, -1);
        idle_cycles(2);

        send_frame(1, 8'h07, 1'b0, 1'b0, -1);
        send_frame(2, 8'h07, 1'b0, 1'b0, -1);
        send_frame(4, 8'($urandom), 1'b0, 1'b0, -1);
        send_frame(3, 8'($urandom), 1'b0, 1'b0, -1);

        // New requests and data changes during a frame must be ignored
        send_frame(0, 8'h22, 1'b0, 1'b1, -1);
        idle_cycles(2);

        // Reset during data bit 3, then a clean frame on the first edge
        send_frame(0, 8'($urandom), 1'b0, 1'b0, 16 * 4 + 5);
        send_frame(0, 8'h3C, 1'b0, 1'b0, -1);
        idle_cycles(2);

        hold = 1'b0;
        idx  = 0;
        for (int r = 0; r < 14; r++) begin
            if (!hold) idx = $urandom_range(0, N - 1);
            hold = ($urandom_range(0, 2) == 0);
            send_frame(idx, 8'($urandom), hold, !hold && ($urandom_range(0, 1) == 1), -1);
            if (!hold && $urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 5));
        end
        if (hold) send_frame(idx, 8'($urandom), 1'b0, 1'b0, -1);
        idle_cycles(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
